// File: rtl/tpu_seq_pkg.sv
// Shared types and helpers for the TPU instruction sequencer: opcode
// encoding, FSM state constants and the host instruction record.
package tpu_seq_pkg;

    localparam int SEQ_ADDR_W = 13;

    typedef enum logic [2:0] {
        OP_NOP         = 3'd0,
        OP_LOAD_WEIGHT = 3'd1,
        OP_LOAD_INPUT  = 3'd2,
        OP_MATMUL      = 3'd3,
        OP_STORE       = 3'd4,
        OP_HALT        = 3'd7
    } opcode_e;

    // Sequencer FSM state encoding.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_ISSUE   = 2'd1;
    localparam state_t ST_COMPUTE = 2'd2;
    localparam state_t ST_DRAIN   = 2'd3;

    // One host instruction as presented on the instr_* port.
    typedef struct packed {
        opcode_e                 opcode;
        logic [SEQ_ADDR_W-1:0]   addr;
    } instr_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seq_instr_fifo.sv
// Small synchronous FIFO holding queued host instructions. Depth must be a
// power of two so the pointers wrap naturally.
module seq_instr_fifo
    import tpu_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    // A full queue refuses a push even if an entry leaves in the same cycle.
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;

    // Next pointer and occupancy values.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latches.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: non-blocking assignments so all flops update from pre-edge values.
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage.
    // NOTE: storage is not reset; an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/tpu_sequencer.sv
// Instruction sequencer for the 2x2 systolic datapath. Host instructions are
// queued, then executed in order as registered one-cycle strobes (or a
// MM_CYCLES-long valid window for MATMUL followed by a drain gap).
module tpu_sequencer
    import tpu_seq_pkg::*;
#(
    parameter int ADDR_W       = 13,
    parameter int QUEUE_DEPTH  = 4,
    parameter int MM_CYCLES    = 5,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        instr_opcode,
    input  logic [ADDR_W-1:0] instr_addr,
    output logic              load_weight,
    output logic              load_input,
    output logic              valid,
    output logic              store,
    output logic [ADDR_W-1:0] base_address,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CNT_W  = $clog2(max_int(MM_CYCLES, DRAIN_CYCLES) + 1);
    localparam int FIFO_W = 3 + ADDR_W;
    localparam int FCNT_W = $clog2(QUEUE_DEPTH) + 1;

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [FIFO_W-1:0] fifo_wdata, fifo_rdata;
    logic [FCNT_W-1:0] fifo_count;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              w_loaded_q, w_loaded_d;
    logic              i_loaded_q, i_loaded_d;
    logic              err_q, err_d;
    logic              load_weight_q, load_weight_d;
    logic              load_input_q, load_input_d;
    logic              store_q, store_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] base_address_q, base_address_d;
    logic              finish_mm;

    // The host sees no room while reset is held, whatever the queue holds.
    assign instr_ready = reset & ~fifo_full;
    assign fifo_push   = instr_valid & instr_ready;
    assign fifo_wdata  = {instr_opcode, instr_addr};

    seq_instr_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (fifo_wdata),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Sequencer FSM: fetch, issue, hold valid for a MATMUL, then drain.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        op_d           = op_q;
        addr_d         = addr_q;
        w_loaded_d     = w_loaded_q;
        i_loaded_d     = i_loaded_q;
        err_d          = err_q;
        load_weight_d  = 1'b0;
        load_input_d   = 1'b0;
        store_d        = 1'b0;
        valid_d        = 1'b0;
        done_d         = 1'b0;
        base_address_d = base_address_q;
        fifo_pop       = 1'b0;
        finish_mm      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    op_d     = fifo_rdata[FIFO_W-1 -: 3];
                    addr_d   = fifo_rdata[ADDR_W-1:0];
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_IDLE;
                case (op_q)
                    OP_NOP: ;
                    OP_LOAD_WEIGHT: begin
                        load_weight_d  = 1'b1;
                        base_address_d = addr_q;
                        w_loaded_d     = 1'b1;
                    end
                    OP_LOAD_INPUT: begin
                        load_input_d   = 1'b1;
                        base_address_d = addr_q;
                        i_loaded_d     = 1'b1;
                    end
                    OP_STORE: begin
                        store_d        = 1'b1;
                        base_address_d = addr_q;
                    end
                    OP_MATMUL: begin
                        // Computing without both operands resident is a program error.
                        if (w_loaded_q && i_loaded_q) begin
                            valid_d = 1'b1;
                            if (MM_CYCLES > 1) begin
                                state_d = ST_COMPUTE;
                                cnt_d   = CNT_W'(MM_CYCLES - 1);
                            end else begin
                                finish_mm = 1'b1;
                            end
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    OP_HALT: done_d = 1'b1;
                    default: err_d = 1'b1;
                endcase
            end
            ST_COMPUTE: begin
                // The ISSUE cycle already supplied the first valid cycle.
                valid_d = 1'b1;
                if (cnt_q == CNT_W'(1)) finish_mm = 1'b1;
                else                    cnt_d = cnt_q - CNT_W'(1);
            end
            ST_DRAIN: begin
                if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
                else                    cnt_d = cnt_q - CNT_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase

        // End of a MATMUL: inputs are consumed, weights stay resident.
        if (finish_mm) begin
            i_loaded_d = 1'b0;
            if (DRAIN_CYCLES > 0) begin
                state_d = ST_DRAIN;
                cnt_d   = CNT_W'(DRAIN_CYCLES);
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    // State, instruction register, flags and registered datapath strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            op_q           <= '0;
            addr_q         <= '0;
            w_loaded_q     <= 1'b0;
            i_loaded_q     <= 1'b0;
            err_q          <= 1'b0;
            load_weight_q  <= 1'b0;
            load_input_q   <= 1'b0;
            store_q        <= 1'b0;
            valid_q        <= 1'b0;
            done_q         <= 1'b0;
            base_address_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            op_q           <= op_d;
            addr_q         <= addr_d;
            w_loaded_q     <= w_loaded_d;
            i_loaded_q     <= i_loaded_d;
            err_q          <= err_d;
            load_weight_q  <= load_weight_d;
            load_input_q   <= load_input_d;
            store_q        <= store_d;
            valid_q        <= valid_d;
            done_q         <= done_d;
            base_address_q <= base_address_d;
        end
    end

    assign load_weight  = load_weight_q;
    assign load_input   = load_input_q;
    assign store        = store_q;
    assign valid        = valid_q;
    assign done         = done_q;
    assign err          = err_q;
    assign base_address = base_address_q;
    assign busy         = (state_q != ST_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_tpu_sequencer.sv
// Self-checking bench for tpu_sequencer. A monitor turns the strobe outputs
// into an event trace; a program-level model predicts the same trace.
module tb_tpu_sequencer;
    import tpu_seq_pkg::*;

    localparam int ADDR_W       = 13;
    localparam int QUEUE_DEPTH  = 4;
    localparam int MM_CYCLES    = 5;
    localparam int DRAIN_CYCLES = 2;

    localparam int EV_LW = 1, EV_LI = 2, EV_ST = 3, EV_MM = 4, EV_DONE = 5;

    typedef struct {
        int                kind;
        logic [ADDR_W-1:0] addr;
        int                len;
        int                cyc;
    } event_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              instr_valid = 1'b0;
    logic              instr_ready;
    logic [2:0]        instr_opcode = '0;
    logic [ADDR_W-1:0] instr_addr = '0;
    logic              load_weight, load_input, valid, store, busy, done, err;
    logic [ADDR_W-1:0] base_address;

    int     n_cmp = 0;
    int     n_bad = 0;
    int     cyc = 0;
    int     vrun = 0;
    int     strobe_viol = 0;
    event_t obs_q[$];
    event_t exp_q[$];
    instr_t prog_q[$];
    int     stall_q[$];
    logic   m_wl = 1'b0, m_il = 1'b0, m_err = 1'b0;
    logic [ADDR_W-1:0] m_last_addr = '0;

    tpu_sequencer #(
        .ADDR_W       (ADDR_W),
        .QUEUE_DEPTH  (QUEUE_DEPTH),
        .MM_CYCLES    (MM_CYCLES),
        .DRAIN_CYCLES (DRAIN_CYCLES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_opcode (instr_opcode),
        .instr_addr   (instr_addr),
        .load_weight  (load_weight),
        .load_input   (load_input),
        .valid        (valid),
        .store        (store),
        .base_address (base_address),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic event_t mk_ev(input int kind, input logic [ADDR_W-1:0] addr,
                                     input int len, input int c);
        event_t e;
        e.kind = kind; e.addr = addr; e.len = len; e.cyc = c;
        return e;
    endfunction

    function automatic bit ev_eq(input event_t a, input event_t b);
        return (a.kind == b.kind) && (a.addr == b.addr) && (a.len == b.len);
    endfunction

    // Monitor: sample outputs on the falling edge and build the event trace.
    initial forever begin
        @(negedge clk);
        if (reset !== 1'b1) begin
            vrun = 0;
        end else begin
            if (valid === 1'b1) vrun++;
            else if (vrun > 0) begin
                obs_q.push_back(mk_ev(EV_MM, '0, vrun, cyc - vrun));
                vrun = 0;
            end
            if (load_weight === 1'b1) obs_q.push_back(mk_ev(EV_LW, base_address, 1, cyc));
            if (load_input === 1'b1)  obs_q.push_back(mk_ev(EV_LI, base_address, 1, cyc));
            if (store === 1'b1)       obs_q.push_back(mk_ev(EV_ST, base_address, 1, cyc));
            if (done === 1'b1)        obs_q.push_back(mk_ev(EV_DONE, '0, 1, cyc));
            if (int'(load_weight) + int'(load_input) + int'(store) > 1) strobe_viol++;
            if (valid && (load_weight || load_input || store)) strobe_viol++;
        end
    end

    // Program-level reference: what the executed instruction list must produce.
    task automatic model_run();
        foreach (prog_q[i]) begin
            case (prog_q[i].opcode)
                OP_LOAD_WEIGHT: begin
                    exp_q.push_back(mk_ev(EV_LW, prog_q[i].addr, 1, 0));
                    m_wl = 1'b1; m_last_addr = prog_q[i].addr;
                end
                OP_LOAD_INPUT: begin
                    exp_q.push_back(mk_ev(EV_LI, prog_q[i].addr, 1, 0));
                    m_il = 1'b1; m_last_addr = prog_q[i].addr;
                end
                OP_STORE: begin
                    exp_q.push_back(mk_ev(EV_ST, prog_q[i].addr, 1, 0));
                    m_last_addr = prog_q[i].addr;
                end
                OP_MATMUL: begin
                    if (m_wl && m_il) begin
                        exp_q.push_back(mk_ev(EV_MM, '0, MM_CYCLES, 0));
                        m_il = 1'b0;
                    end else m_err = 1'b1;
                end
                OP_HALT: exp_q.push_back(mk_ev(EV_DONE, '0, 1, 0));
                OP_NOP: ;
                default: m_err = 1'b1;
            endcase
        end
        prog_q.delete();
    endtask

    // Present one instruction from a falling edge; returns the accepting edge number.
    task automatic push_instr(input logic [2:0] op, input logic [ADDR_W-1:0] addr,
                              output int acc);
        int     waited;
        logic   ok;
        instr_t it;
        waited = 0;
        acc = -1;
        instr_valid = 1'b1; instr_opcode = op; instr_addr = addr;
        while (1) begin
            ok = instr_ready;
            @(posedge clk);
            if (ok) break;
            waited++;
            if (waited > 200) break;
            @(negedge clk);
        end
        @(negedge clk);
        instr_valid = 1'b0;
        stall_q.push_back((waited > 0) ? 1 : 0);
        if (waited > 200) begin
            n_cmp++; n_bad++;
            $display("FAIL push_timeout: opcode %0d not accepted after %0d cycles, required acceptance", op, waited);
        end else begin
            acc = cyc;
            it.opcode = opcode_e'(op);
            it.addr = addr;
            prog_q.push_back(it);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_idle_timeout: busy=%b after %0d cycles, required 0", name, busy, n);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_valid_timeout: valid=%b after %0d cycles, required 1", name, valid, n);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        obs_q.delete(); exp_q.delete(); prog_q.delete();
        m_wl = 1'b0; m_il = 1'b0; m_err = 1'b0; m_last_addr = '0;
    endtask

    task automatic test_reset();
        logic [7:0] got;
        #2 reset = 1'b0;
        @(negedge clk);
        got = {load_weight, load_input, valid, store, busy, done, err, instr_ready};
        n_cmp++;
        if (got !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b, required 00000000", got);
        end
        n_cmp++;
        if (base_address !== '0) begin
            n_bad++;
            $display("FAIL reset_base_address: got %h, required 0", base_address);
        end
        reset = 1'b1;
        @(negedge clk);
        got = {load_weight, load_input, valid, store, busy, done, err, instr_ready};
        n_cmp++;
        if (got !== 8'h01) begin
            n_bad++;
            $display("FAIL reset_release: got %b, required 00000001", got);
        end
    endtask

    task automatic test_single_load();
        int acc;
        obs_q.delete(); exp_q.delete();
        push_instr(OP_LOAD_WEIGHT, 13'h010, acc);
        wait_idle("t1");
        model_run();
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL t1_trace_len: got %0d events, required %0d", obs_q.size(), exp_q.size());
        end else begin
            n_cmp++;
            if (!ev_eq(obs_q[0], exp_q[0])) begin
                n_bad++;
                $display("FAIL t1_event: got kind=%0d addr=%h, required kind=%0d addr=%h",
                         obs_q[0].kind, obs_q[0].addr, exp_q[0].kind, exp_q[0].addr);
            end
            n_cmp++;
            if (obs_q[0].cyc != acc + 2) begin
                n_bad++;
                $display("FAIL t1_latency: strobe at edge %0d, required %0d", obs_q[0].cyc, acc + 2);
            end
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL t1_busy: got %b, required 0", busy);
        end
    endtask

    task automatic test_program();
        int acc;
        obs_q.delete(); exp_q.delete();
        push_instr(OP_LOAD_WEIGHT, 13'h000, acc);
        push_instr(OP_LOAD_INPUT,  13'h020, acc);
        push_instr(OP_MATMUL,      13'h000, acc);
        push_instr(OP_STORE,       13'h040, acc);
        push_instr(OP_HALT,        13'h000, acc);
        wait_idle("t2");
        model_run();
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL t2_trace_len: got %0d events, required %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_cmp++;
            if (!ev_eq(obs_q[i], exp_q[i])) begin
                n_bad++;
                $display("FAIL t2_event%0d: got kind=%0d addr=%h len=%0d, required kind=%0d addr=%h len=%0d",
                         i, obs_q[i].kind, obs_q[i].addr, obs_q[i].len,
                         exp_q[i].kind, exp_q[i].addr, exp_q[i].len);
            end
        end
        if (obs_q.size() == 5) begin
            n_cmp++;
            if (obs_q[1].cyc - obs_q[0].cyc != 2) begin
                n_bad++;
                $display("FAIL t2_issue_rate: loads %0d cycles apart, required 2", obs_q[1].cyc - obs_q[0].cyc);
            end
            n_cmp++;
            if (obs_q[3].cyc - (obs_q[2].cyc + obs_q[2].len) < 2) begin
                n_bad++;
                $display("FAIL t2_store_gap: store %0d cycles after valid fell, required >= 2",
                         obs_q[3].cyc - (obs_q[2].cyc + obs_q[2].len));
            end
        end
        n_cmp++;
        if (err !== m_err) begin
            n_bad++;
            $display("FAIL t2_err: got %b, required %b", err, m_err);
        end
    endtask

    task automatic test_errors();
        int acc;
        apply_reset();
        push_instr(OP_MATMUL,      13'h000, acc);
        push_instr(3'd5,           13'h000, acc);
        push_instr(OP_LOAD_WEIGHT, 13'h123, acc);
        wait_idle("t3");
        model_run();
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL t3_trace_len: got %0d events, required %0d", obs_q.size(), exp_q.size());
        end else if (obs_q.size() > 0) begin
            n_cmp++;
            if (!ev_eq(obs_q[0], exp_q[0])) begin
                n_bad++;
                $display("FAIL t3_event: got kind=%0d addr=%h, required kind=%0d addr=%h",
                         obs_q[0].kind, obs_q[0].addr, exp_q[0].kind, exp_q[0].addr);
            end
        end
        n_cmp++;
        if (err !== m_err) begin
            n_bad++;
            $display("FAIL t3_err_sticky: got %b, required %b", err, m_err);
        end
    endtask

    task automatic test_backpressure();
        int acc;
        logic [ADDR_W-1:0] tail [6];
        int exp_stall [5];
        tail = '{13'h201, 13'h202, 13'h203, 13'h204, 13'h205, 13'h206};
        exp_stall = '{0, 0, 0, 0, 1};
        obs_q.delete(); exp_q.delete();
        push_instr(OP_LOAD_INPUT, 13'h100, acc);
        push_instr(OP_MATMUL,     13'h000, acc);
        wait_valid("t4");
        stall_q.delete();
        for (int i = 0; i < 6; i++) begin
            push_instr((i % 3 == 1) ? 3'(OP_LOAD_WEIGHT) : ((i == 3) ? 3'(OP_LOAD_INPUT) : 3'(OP_STORE)),
                       tail[i], acc);
        end
        wait_idle("t4");
        model_run();
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (stall_q[i] != exp_stall[i]) begin
                n_bad++;
                $display("FAIL t4_ready_push%0d: stalled=%0d, required %0d", i, stall_q[i], exp_stall[i]);
            end
        end
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL t4_trace_len: got %0d events, required %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_cmp++;
            if (!ev_eq(obs_q[i], exp_q[i])) begin
                n_bad++;
                $display("FAIL t4_event%0d: got kind=%0d addr=%h len=%0d, required kind=%0d addr=%h len=%0d",
                         i, obs_q[i].kind, obs_q[i].addr, obs_q[i].len,
                         exp_q[i].kind, exp_q[i].addr, exp_q[i].len);
            end
        end
    endtask

    task automatic test_reset_mid_compute();
        int acc;
        logic [4:0] got;
        push_instr(OP_LOAD_WEIGHT, 13'h301, acc);
        push_instr(OP_LOAD_INPUT,  13'h302, acc);
        push_instr(OP_MATMUL,      13'h000, acc);
        push_instr(OP_STORE,       13'h303, acc);
        push_instr(OP_STORE,       13'h304, acc);
        wait_valid("t5");
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        got = {valid, load_weight, store, busy, instr_ready};
        n_cmp++;
        if (got !== 5'b00000) begin
            n_bad++;
            $display("FAIL t5_async_abort: valid/lw/st/busy/ready=%b, required 00000", got);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        obs_q.delete(); exp_q.delete(); prog_q.delete();
        m_wl = 1'b0; m_il = 1'b0; m_err = 1'b0; m_last_addr = '0;
        #1;
        got = {busy, instr_ready, err, valid, 1'b0};
        n_cmp++;
        if (got !== 5'b01000) begin
            n_bad++;
            $display("FAIL t5_after_release: busy/ready/err/valid=%b, required 0100", got[4:1]);
        end
        @(negedge clk);
        push_instr(OP_MATMUL, 13'h000, acc);
        wait_idle("t5");
        model_run();
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL t5_trace_len: got %0d events, required %0d", obs_q.size(), exp_q.size());
        end
        n_cmp++;
        if (err !== m_err) begin
            n_bad++;
            $display("FAIL t5_err: got %b, required %b", err, m_err);
        end
    endtask

    task automatic test_random();
        int acc, r, nerr;
        logic [2:0] op;
        apply_reset();
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 99);
            if      (r < 25) op = OP_LOAD_WEIGHT;
            else if (r < 50) op = OP_LOAD_INPUT;
            else if (r < 70) op = OP_MATMUL;
            else if (r < 85) op = OP_STORE;
            else if (r < 90) op = OP_NOP;
            else if (r < 95) op = OP_HALT;
            else             op = 3'($urandom_range(5, 6));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            push_instr(op, ADDR_W'($urandom_range(0, 8191)), acc);
        end
        wait_idle("rnd");
        model_run();
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL rnd_trace_len: got %0d events, required %0d", obs_q.size(), exp_q.size());
        end
        nerr = 0;
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_cmp++;
            if (!ev_eq(obs_q[i], exp_q[i])) begin
                n_bad++;
                nerr++;
                if (nerr <= 5)
                    $display("FAIL rnd_event%0d: got kind=%0d addr=%h len=%0d, required kind=%0d addr=%h len=%0d",
                             i, obs_q[i].kind, obs_q[i].addr, obs_q[i].len,
                             exp_q[i].kind, exp_q[i].addr, exp_q[i].len);
            end
        end
        n_cmp++;
        if (err !== m_err) begin
            n_bad++;
            $display("FAIL rnd_err: got %b, required %b", err, m_err);
        end
        n_cmp++;
        if (base_address !== m_last_addr) begin
            n_bad++;
            $display("FAIL rnd_base_hold: got %h, required %h", base_address, m_last_addr);
        end
        n_cmp++;
        if (strobe_viol != 0) begin
            n_bad++;
            $display("FAIL strobe_exclusive: %0d cycles with overlapping strobes, required 0", strobe_viol);
        end
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_program();
        test_errors();
        test_backpressure();
        test_reset_mid_compute();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench still running at %0t, required completion", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/tpu_sequencer.md
Name: tpu_sequencer

Overview:
- Instruction-driven sequencer for the 2x2 systolic datapath (weight memory, unified buffer, input setup, MMU, accumulators).
- Accepts host instructions over a valid/ready handshake into a small queue.
- Executes them in order by driving the datapath strobes `load_weight`, `load_input`, `valid`, `store` and `base_address` with fixed, parameterised timing.
- Replaces the hard-wired start-triggered program with a queued, error-checked instruction stream.

Parameters:
- ADDR_W, 13, width of base_address and instruction address field
- QUEUE_DEPTH, 4, instruction queue entries (power of two, >=2)
- MM_CYCLES, 5, cycles `valid` is held high for one MATMUL (2 rows + 2 skew + 1)
- DRAIN_CYCLES, 2, idle cycles after MATMUL before next instruction may issue

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately
- instr_valid  in  1  host presents an instruction
- instr_ready  out  1  queue can accept; transfer on `instr_valid & instr_ready` at a rising edge
- instr_opcode  in  3  opcode: NOP=0, LOAD_WEIGHT=1, LOAD_INPUT=2, MATMUL=3, STORE=4, HALT=7; 5 and 6 illegal
- instr_addr  in  ADDR_W  base address for LOAD_WEIGHT / LOAD_INPUT / STORE
- load_weight  out  1  one-cycle strobe to MMU and weight memory
- load_input  out  1  one-cycle strobe to unified buffer
- valid  out  1  compute enable to input setup, MMU and accumulators
- store  out  1  one-cycle strobe to unified buffer
- base_address  out  ADDR_W  address for current strobe; holds last value otherwise
- busy  out  1  FSM not IDLE or queue non-empty
- done  out  1  one-cycle pulse when HALT retires
- err  out  1  sticky error flag; cleared only by reset

Behaviour:
- Reset (`reset`=0, asynchronous): all outputs 0, `base_address`=0, queue emptied, FSM=IDLE, `weights_loaded`=`inputs_loaded`=0.
  - Reset mid-instruction aborts it with no further strobes.
  - `instr_ready` is 0 during reset.
- Queue:
  - `instr_ready` = (count < QUEUE_DEPTH), derived from registered count only.
  - When full, no push occurs even if a pop happens the same cycle.
  - Simultaneous push and pop when not full leaves count unchanged.
  - Pointers wrap modulo QUEUE_DEPTH.
- FSM states: IDLE, ISSUE, COMPUTE, DRAIN.
  - IDLE: if queue non-empty, pop head into the instruction register and go to ISSUE.
  - ISSUE (exactly 1 cycle), then back to IDLE unless noted:
    - LOAD_WEIGHT: `load_weight`=1, `base_address`=addr, set `weights_loaded`.
    - LOAD_INPUT: `load_input`=1, `base_address`=addr, set `inputs_loaded`.
    - STORE: `store`=1, `base_address`=addr.
    - MATMUL with both flags set: `valid`=1 and go to COMPUTE.
    - MATMUL with either flag clear: set `err`, no strobe.
    - NOP: no strobe.
    - HALT: `done`=1.
    - Illegal opcode: set `err`, no strobe.
  - COMPUTE: `valid` stays 1 for a total of exactly MM_CYCLES consecutive cycles, counting the ISSUE cycle. Then go to DRAIN and clear `inputs_loaded`; weights stay resident.
  - DRAIN: all strobes 0 for DRAIN_CYCLES cycles, then IDLE.
- Latency:
  - An instruction accepted at edge N into an empty queue with FSM in IDLE drives its strobe during the cycle after edge N+2.
  - Back-to-back non-MATMUL instructions issue every 2 cycles (IDLE, ISSUE).
- Strobe rules:
  - At most one of `load_weight` / `load_input` / `store` is high in any cycle.
  - `valid` is never high together with any of the other strobes.
  - Instructions queued during COMPUTE/DRAIN wait; none are dropped.
- `busy` is combinational from state and count. `err` never blocks execution.
- Counters: the COMPUTE/DRAIN down-counter is $clog2(max(MM_CYCLES, DRAIN_CYCLES)+1) bits wide and never wraps.

Decomposition:
- Package tpu_seq_pkg: opcode enum (3-bit), FSM state enum, instruction struct (opcode + addr).
- Sub-module seq_instr_fifo: synchronous FIFO, QUEUE_DEPTH x (3+ADDR_W), push/pop/full/empty/count.
  - Same clock and active-low async reset as tpu_sequencer.

Test Plan:
1. Reset release, push LOAD_WEIGHT addr=0x010 -> `load_weight`=1 for exactly 1 cycle with `base_address`=0x010, 2 cycles after acceptance; `busy` drops after.
2. Program LOAD_WEIGHT 0x000, LOAD_INPUT 0x020, MATMUL, STORE 0x040, HALT -> `valid` high exactly 5 consecutive cycles; `store` with `base_address`=0x040 no earlier than 2 cycles after `valid` falls; one `done` pulse; `err`=0.
3. MATMUL with no prior loads, then opcode 5 -> `valid` never asserted; `err`=1 and stays 1 after a subsequent legal LOAD_WEIGHT executes normally.
4. Hold `instr_valid`=1 during a MATMUL with 6 queued instructions -> `instr_ready`=0 once 4 entries are held; no instruction lost or reordered (check `base_address` sequence).
5. Assert `reset`=0 mid-COMPUTE (cycle 3 of 5) -> `valid` drops asynchronously; after release queue is empty, `instr_ready`=1, and MATMUL raises `err` because the loaded flags are cleared.
